// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and NOP constant for pipeline stage registers
package pipe_pkg;

  localparam int unsigned PIPE_DEF_WIDTH = 96;

  // All-zero payload is the NOP presented downstream when nothing is valid.
  localparam logic [PIPE_DEF_WIDTH-1:0] PIPE_NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] pipe_occ(input pipe_state_e s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_en_reg.sv
// rtl/pipe_en_reg.sv - enabled payload register with asynchronous reset to the NOP value
module pipe_en_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= FLUSH_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with optional skid entry, flush, stall and bubble count
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_DEF_WIDTH,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(PIPE_NOP),
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  pipe_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_en, skid_en;
  logic             in_hs, out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  pipe_en_reg #(
    .WIDTH     (WIDTH),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_main_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_en_reg #(
    .WIDTH     (WIDTH),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_en),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      ready_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      bubble_q <= bubble_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = FLUSH_VAL;
    skid_en = 1'b0;
    skid_d  = FLUSH_VAL;
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      skid_en = 1'b1;
    end else if (!stall) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            state_d = ST_FULL;
            main_en = 1'b1;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_hs && out_hs) begin
            main_en = 1'b1;
            main_d  = in_data;
          end else if (in_hs && (SKID != 0)) begin
            state_d = ST_SKID;
            skid_en = 1'b1;
            skid_d  = in_data;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
            main_en = 1'b1;
          end
        end
        ST_SKID: begin
          if (out_hs) begin
            state_d = ST_FULL;
            main_en = 1'b1;
            main_d  = skid_q;
            skid_en = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Registered ready looks one state ahead so it never admits into a full skid pair.
    ready_d = (state_d != ST_SKID);

    bubble_d = bubble_q;
    if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_comb begin
    logic rdy;
    rdy       = (SKID != 0) ? ready_q : ((state_q == ST_EMPTY) || out_ready);
    in_ready  = rdy && !stall && !flush && !reset;
    out_valid = (state_q != ST_EMPTY) && !stall;
    out_data  = out_valid ? main_q : FLUSH_VAL;
    occupancy = pipe_occ(state_q);
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue-based reference
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         flush = 1'b0;
  logic         stall = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [3:0]   bubble_cnt;

  logic         in_valid0 = 1'b0;
  logic         in_ready0;
  logic [W-1:0] in_data0 = '0;
  logic         flush0 = 1'b0;
  logic         stall0 = 1'b0;
  logic         out_valid0;
  logic         out_ready0 = 1'b0;
  logic [W-1:0] out_data0;
  logic [1:0]   occupancy0;
  logic [3:0]   bubble_cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .FLUSH_VAL('0), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .FLUSH_VAL('0), .CNT_W(4)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid0),
    .in_ready   (in_ready0),
    .in_data    (in_data0),
    .flush      (flush0),
    .stall      (stall0),
    .out_valid  (out_valid0),
    .out_ready  (out_ready0),
    .out_data   (out_data0),
    .occupancy  (occupancy0),
    .bubble_cnt (bubble_cnt0)
  );

  int tests = 0;
  int fails = 0;

  // Reference: the stage is a FIFO of at most two payloads; ready is off until the first edge after reset.
  logic [W-1:0] mq[$];
  bit           armed = 1'b0;
  int           bub = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic         ev;
    logic         er;
    logic [W-1:0] ed;
    #1;
    ev = !reset && (mq.size() > 0) && !stall;
    ed = ev ? mq[0] : '0;
    er = !reset && armed && (mq.size() < 2) && !stall && !flush;
    check("out_valid", W'(out_valid), W'(ev));
    check("out_data", out_data, ed);
    check("occupancy", W'(occupancy), W'(mq.size()));
    check("in_ready", W'(in_ready), W'(er));
    check("bubble_cnt", W'(bubble_cnt), W'(bub));
    @(posedge clk);
    if (!reset) begin
      if (!ev && out_ready && bub < 15) bub++;
      if (flush) begin
        mq.delete();
      end else if (!stall) begin
        if (ev && out_ready) void'(mq.pop_front());
        if (in_valid && er) mq.push_back(in_data);
      end
      armed = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit st, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mq.delete();
    bub   = 0;
    armed = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_occupancy", W'(occupancy), '0);
    check("rst_bubble_cnt", W'(bubble_cnt), '0);
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_in_ready0", W'(in_ready0), '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Single payload with one-cycle latency.
    drive(0, '0, 1, 0, 0);
    drive(1, 32'h1111, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);

    // Fill both entries under back-pressure, then drain in order.
    drive(1, 32'hA, 0, 0, 0);
    drive(1, 32'hB, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    check("skid_full_occ", W'(occupancy), 32'd2);
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0);

    // Flush beats stall and discards the concurrent input.
    drive(1, 32'hA2, 0, 0, 0);
    drive(1, 32'hB2, 0, 0, 0);
    drive(1, 32'hC, 1, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);

    // Stall holds a single entry, then it is emitted exactly once.
    drive(1, 32'hD, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);

    // Reset mid-transfer drops held payloads.
    drive(1, 32'hE1, 0, 0, 0);
    drive(1, 32'hE2, 0, 0, 0);
    in_valid = 1'b1;
    in_data  = 32'hE3;
    apply_reset();
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0);

    // Bubble counter saturation and reset.
    drive(0, '0, 0, 0, 0);
    apply_reset();
    for (int i = 0; i < 20; i++) drive(0, '0, 1, 0, 0);
    check("bubble_sat", W'(bubble_cnt), 32'd15);
    drive(0, '0, 0, 0, 0);
    apply_reset();

    // Single-register variant streams back-to-back.
    out_ready0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid0 = (i < 8);
      in_data0  = W'(i + 1);
      #1;
      if (i < 8) check("s0_in_ready", W'(in_ready0), 32'd1);
      check("s0_out_valid", W'(out_valid0), W'(i > 0));
      check("s0_out_data", out_data0, (i > 0) ? W'(i) : '0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid0 = 1'b1;
    in_data0  = 32'h55;
    #1;
    check("s0_empty_ready", W'(in_ready0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid0  = 1'b0;
    out_ready0 = 1'b0;
    #1;
    check("s0_bp_ready", W'(in_ready0), 32'd0);
    check("s0_bp_data", out_data0, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 96, payload width in bits (IR + PC+4 + PC).
REQ-002 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter FLUSH_VAL, default all-zero WIDTH bits, value driven on out_data when out_valid=0 (NOP encoding).
REQ-004 Parameter CNT_W, default 16, width of bubble counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  upstream payload valid.
REQ-008 in_ready  out  1  stage accepts payload this cycle.
REQ-009 in_data  in  WIDTH  upstream payload.
REQ-010 flush  in  1  discard all held payloads (branch/jump taken).
REQ-011 stall  in  1  freeze stage (hazard hold).
REQ-012 out_valid  out  1  downstream payload valid.
REQ-013 out_ready  in  1  downstream accepts payload.
REQ-014 out_data  out  WIDTH  downstream payload.
REQ-015 occupancy  out  2  number of held entries (0..2).
REQ-016 bubble_cnt  out  CNT_W  count of bubbles presented downstream.

Function
REQ-017 Input handshake SHALL occur when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-018 Latency SHALL be 1 cycle: payload accepted at edge k appears on out_data with out_valid=1 immediately after edge k when stage was empty.
REQ-019 Control states SHALL be EMPTY (0 entries), FULL (main reg), SKID (main + skid reg); SKID unreachable when SKID=0.
REQ-020 Transitions (no flush/stall): EMPTY+in_hs -> FULL; FULL+in_hs+~out_hs -> SKID; FULL+out_hs+~in_hs -> EMPTY; FULL+in_hs+out_hs -> FULL (new payload replaces old); SKID+out_hs -> FULL (skid moves to main); otherwise hold.
REQ-021 SKID=1: in_ready SHALL be registered, = (next state != SKID), then gated by ~stall & ~flush.
REQ-022 SKID=0: in_ready SHALL be (state==EMPTY | out_ready) & ~stall & ~flush.
REQ-023 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-024 out_valid SHALL be 1 iff state != EMPTY and stall=0; out_data SHALL be FLUSH_VAL whenever out_valid=0.
REQ-025 flush SHALL take priority over stall and handshakes: next state EMPTY, both registers load FLUSH_VAL, in_data of that cycle discarded.
REQ-026 stall (without flush) SHALL hold state and both registers; no input or output handshake occurs.
REQ-027 bubble_cnt SHALL increment by 1 each cycle with out_valid=0 & out_ready=1, saturating at 2^CNT_W-1 (no wrap).
REQ-028 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID.

Reset
REQ-029 reset asserted SHALL immediately force state EMPTY, registers FLUSH_VAL, out_valid=0, out_data=FLUSH_VAL, occupancy=0, bubble_cnt=0, in_ready=0.
REQ-030 in_ready SHALL become 1 on the first rising edge after reset deassertion (when stall=0, flush=0).
REQ-031 Reset mid-transfer SHALL discard all held payloads; no partial handshake is honoured.

Structure
REQ-032 State enum (EMPTY/FULL/SKID) and default NOP constant SHALL live in shared package pipe_pkg.
REQ-033 Payload registers SHALL be instances of one sub-module pipe_en_reg (WIDTH-parameterised, enable, async reset to FLUSH_VAL).

Verification (WIDTH=32, SKID=1, CNT_W=4 unless stated)
REQ-034 Reset, then in_data=0x1111 valid 1 cycle, out_ready=1 -> out_data=0x1111, out_valid=1 one cycle later, then out_valid=0, out_data=0.
REQ-035 out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB in order, in_ready returns 1.
REQ-036 Occupancy 2, flush=1 with stall=1 and in_valid=1 (0xC) -> next cycle occupancy=0, out_valid=0, 0xC never emitted.
REQ-037 Occupancy 1 holding 0xD, stall=1 for 3 cycles -> out_valid=0, out_data=0, occupancy=1; stall=0 -> 0xD emitted once.
REQ-038 Idle, out_ready=1 for 20 cycles -> bubble_cnt saturates at 15; reset -> 0.
REQ-039 SKID=0, out_ready=1, continuous in_valid 0x1..0x8 -> in_ready=1 every cycle, 8 payloads out back-to-back.
